// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator request scheduler: car direction codes,
// scheduler states (numerically equal to the direction they drive) and default sizing.
package elevator_pkg;

   localparam int FLOORS_DEFAULT  = 8;
   localparam int FLOOR_W_DEFAULT = 3;

   localparam logic [1:0] DIR_IDLE = 2'd0;
   localparam logic [1:0] DIR_DOWN = 2'd1;
   localparam logic [1:0] DIR_UP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_DOWN = 2'd1,
      SERVE_UP   = 2'd2
   } sched_state_t;

endpackage

// File: rtl/elevator_floor_search.sv
// Combinational priority finder: nearest/farthest set bit above and below floor c.
// A floor index outside the building counts as above every floor.
module elevator_floor_search #(
   parameter int FLOORS  = 8,
   parameter int FLOOR_W = 3
) (
   input  logic [FLOORS-1:0]  vec,
   input  logic [FLOOR_W-1:0] c,
   output logic [FLOOR_W-1:0] lo_above_idx,
   output logic               lo_above_found,
   output logic [FLOOR_W-1:0] hi_above_idx,
   output logic               hi_above_found,
   output logic [FLOOR_W-1:0] hi_below_idx,
   output logic               hi_below_found,
   output logic [FLOOR_W-1:0] lo_below_idx,
   output logic               lo_below_found
);

   logic              c_valid;
   logic [FLOORS-1:0] above;
   logic [FLOORS-1:0] below;

   assign c_valid = int'(c) < FLOORS;

   genvar gi;
   generate
      for (gi = 0; gi < FLOORS; gi++) begin : g_mask
         assign above[gi] = vec[gi] && c_valid && (gi > int'(c));
         assign below[gi] = vec[gi] && (!c_valid || (gi < int'(c)));
      end
   endgenerate

   // Each loop lets the last match win, so scan direction picks lowest vs highest.
   always_comb begin
      lo_above_idx   = '0;
      lo_above_found = 1'b0;
      hi_above_idx   = '0;
      hi_above_found = 1'b0;
      hi_below_idx   = '0;
      hi_below_found = 1'b0;
      lo_below_idx   = '0;
      lo_below_found = 1'b0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (above[i]) begin
            lo_above_idx   = FLOOR_W'(i);
            lo_above_found = 1'b1;
         end
         if (below[i]) begin
            lo_below_idx   = FLOOR_W'(i);
            lo_below_found = 1'b1;
         end
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (above[i]) begin
            hi_above_idx   = FLOOR_W'(i);
            hi_above_found = 1'b1;
         end
         if (below[i]) begin
            hi_below_idx   = FLOOR_W'(i);
            hi_below_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches cabin/hall calls, picks the next target floor.
// Define ELEVATOR_CANCEL_EN to make a second cabin-button press cancel its request.
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int FLOORS  = FLOORS_DEFAULT,
   parameter int FLOOR_W = FLOOR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  btn_num_in,
   input  logic [FLOORS-1:0]  btn_up_out,
   input  logic [FLOORS-1:0]  btn_down_out,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               arrived,
   output logic [FLOOR_W-1:0] next_floor,
   output logic               req_valid,
   output logic [1:0]         direction,
   output logic [FLOORS-1:0]  active_in_levels,
   output logic [FLOORS-1:0]  active_up_levels,
   output logic [FLOORS-1:0]  active_down_levels
);

   localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};
   localparam int N_SRCH    = 5;
   localparam int S_PEND    = 0;
   localparam int S_IN_UP   = 1;
   localparam int S_DOWN    = 2;
   localparam int S_IN_DOWN = 3;
   localparam int S_UP      = 4;

   sched_state_t       state_reg, state_next;
   logic [FLOORS-1:0]  in_reg, in_next, up_reg, up_next, down_reg, down_next;
   logic [FLOORS-1:0]  c_hot, clr_in, clr_up, clr_down, pend;
   logic [FLOOR_W-1:0] next_floor_reg, target;
   logic               req_valid_reg;
   logic               pend_above, pend_below, up_at_c, down_at_c;

   logic [N_SRCH-1:0][FLOORS-1:0]  srch_vec;
   logic [N_SRCH-1:0][FLOOR_W-1:0] lo_above_idx, hi_above_idx, hi_below_idx, lo_below_idx;
   logic [N_SRCH-1:0]              lo_above_found, hi_above_found, hi_below_found, lo_below_found;
   logic                           unused_search;

   genvar gi;
   generate
      for (gi = 0; gi < FLOORS; gi++) begin : g_hot
         assign c_hot[gi] = (current_floor == FLOOR_W'(gi));
      end
   endgenerate

   // Hall-call clears follow the direction being served, so the opposite call survives.
   assign clr_in    = arrived ? c_hot : '0;
   assign clr_up    = (arrived && state_reg != SERVE_DOWN) ? c_hot : '0;
   assign clr_down  = (arrived && state_reg != SERVE_UP) ? c_hot : '0;
   assign up_next   = (up_reg & ~clr_up) | (btn_up_out & UP_MASK);
   assign down_next = (down_reg & ~clr_down) | (btn_down_out & DOWN_MASK);

`ifdef ELEVATOR_CANCEL_EN
   logic [FLOORS-1:0] btn_num_prev_reg;
   logic [FLOORS-1:0] btn_rise;

   always_ff @(posedge clk) begin
      if (!reset) btn_num_prev_reg <= '0;
      else        btn_num_prev_reg <= btn_num_in;
   end

   assign btn_rise = btn_num_in & ~btn_num_prev_reg;
   assign in_next  = (in_reg & ~clr_in & ~btn_rise) | (btn_rise & ~in_reg);
`else
   assign in_next = (in_reg & ~clr_in) | btn_num_in;
`endif

   assign pend                = in_reg | up_reg | down_reg;
   assign srch_vec[S_PEND]    = pend;
   assign srch_vec[S_IN_UP]   = in_reg | up_reg;
   assign srch_vec[S_DOWN]    = down_reg;
   assign srch_vec[S_IN_DOWN] = in_reg | down_reg;
   assign srch_vec[S_UP]      = up_reg;

   generate
      for (gi = 0; gi < N_SRCH; gi++) begin : g_search
         elevator_floor_search #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_search (
            .vec            (srch_vec[gi]),
            .c              (current_floor),
            .lo_above_idx   (lo_above_idx[gi]),
            .lo_above_found (lo_above_found[gi]),
            .hi_above_idx   (hi_above_idx[gi]),
            .hi_above_found (hi_above_found[gi]),
            .hi_below_idx   (hi_below_idx[gi]),
            .hi_below_found (hi_below_found[gi]),
            .lo_below_idx   (lo_below_idx[gi]),
            .lo_below_found (lo_below_found[gi])
         );
      end
   endgenerate

   assign unused_search = ^{lo_above_idx, hi_above_idx, hi_below_idx, lo_below_idx,
                            lo_above_found, hi_above_found, hi_below_found, lo_below_found};

   assign pend_above = lo_above_found[S_PEND];
   assign pend_below = hi_below_found[S_PEND];
   assign up_at_c    = |(up_reg & c_hot);
   assign down_at_c  = |(down_reg & c_hot);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pend_above)      state_next = SERVE_UP;
            else if (pend_below) state_next = SERVE_DOWN;
         end
         SERVE_UP: begin
            if (!pend_above) state_next = (pend_below || down_at_c) ? SERVE_DOWN : IDLE;
         end
         SERVE_DOWN: begin
            if (!pend_below) state_next = (pend_above || up_at_c) ? SERVE_UP : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Target follows the state being entered so next_floor and direction agree on the same cycle.
   always_comb begin
      target = current_floor;
      case (state_next)
         SERVE_UP: begin
            if (lo_above_found[S_IN_UP])     target = lo_above_idx[S_IN_UP];
            else if (hi_above_found[S_DOWN]) target = hi_above_idx[S_DOWN];
         end
         SERVE_DOWN: begin
            if (hi_below_found[S_IN_DOWN])   target = hi_below_idx[S_IN_DOWN];
            else if (lo_below_found[S_UP])   target = lo_below_idx[S_UP];
         end
         default: target = current_floor;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         in_reg         <= '0;
         up_reg         <= '0;
         down_reg       <= '0;
         state_reg      <= IDLE;
         next_floor_reg <= '0;
         req_valid_reg  <= 1'b0;
      end else begin
         in_reg         <= in_next;
         up_reg         <= up_next;
         down_reg       <= down_next;
         state_reg      <= state_next;
         next_floor_reg <= target;
         req_valid_reg  <= |pend;
      end
   end

   always_comb begin
      case (state_reg)
         SERVE_UP:   direction = DIR_UP;
         SERVE_DOWN: direction = DIR_DOWN;
         default:    direction = DIR_IDLE;
      endcase
   end

   assign next_floor         = next_floor_reg;
   assign req_valid          = req_valid_reg;
   assign active_in_levels   = in_reg;
   assign active_up_levels   = up_reg;
   assign active_down_levels = down_reg;

endmodule
